cmos_capture_rgb565: RTL

//  Camera-side writer for the SDRAM frame buffer: samples an OV7670-style 8-bit DVP stream, pairs bytes into
//  RGB565 pixels and drives the write port of the SDRAM dual-FIFO (sys_we/sys_data_in). It is the producer

---
 rtl/cmos_capture_rgb565.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/cmos_capture_rgb565.sv
// cmos_capture_rgb565: OV7670-style 8-bit DVP capture into RGB565 FIFO writes.
// Optional colour-bar test pattern is compiled in with `define CAP_TESTPAT_EN.
module cmos_capture_rgb565 #(
  parameter int unsigned H_PIXELS   = 640,
  parameter int unsigned V_LINES    = 480,
  parameter int unsigned FRAME_SKIP = 10,
  parameter bit          VS_POL     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_init_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        test_mode,
  output logic        sys_we,
  output logic [15:0] sys_data_in,
  output logic        frame_valid,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        size_err
);

  localparam int unsigned PIX_W  = 11;
  localparam int unsigned LINE_W = 10;
  localparam int unsigned SKIP_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 16;

  localparam logic [PIX_W-1:0]  PIX_MAX  = '1;
  localparam logic [PIX_W-1:0]  H_LIM    = PIX_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] V_LIM    = LINE_W'(V_LINES);
  localparam logic [LINE_W-1:0] V_SAT    = LINE_W'(V_LINES + 1);
  localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(FRAME_SKIP);

  typedef enum logic [1:0] {
    WAIT_INIT,
    SKIP,
    WAIT_VS,
    CAPTURE
  } state_t;

  state_t state, state_nxt;

  logic              vs_r, hr_r, vs_act_d, hr_d;
  logic [7:0]        d_r;
  logic              vs_act_c, frame_start_c, frame_end_c, line_end_c;

  logic [SKIP_W-1:0] skip_cnt, skip_nxt;
  logic [LINE_W-1:0] line_cnt, line_nxt;
  logic [PIX_W-1:0]  pix_cnt, pix_nxt;
  logic              phase, phase_nxt;
  logic [7:0]        hi, hi_nxt;
  logic              we_nxt, done_nxt, valid_nxt, err_nxt;
  logic [DATA_W-1:0] data_nxt, pix_rgb_c;
  logic [CNT_W-1:0]  fcnt_nxt;

  assign vs_act_c      = (vs_r == VS_POL);
  assign frame_start_c = vs_act_d & ~vs_act_c;
  assign frame_end_c   = ~vs_act_d & vs_act_c;
  assign line_end_c    = hr_d & ~hr_r;

`ifdef CAP_TESTPAT_EN
  localparam int unsigned BAR_W = (H_PIXELS / 8 == 0) ? 1 : H_PIXELS / 8;
  logic [2:0]        bar_idx_c;
  logic [DATA_W-1:0] bar_rgb_c;

  assign bar_idx_c = 3'(pix_cnt / PIX_W'(BAR_W));

  // Colour-bar lookup for the current pixel column
  always_comb begin
    bar_rgb_c = 16'h0000;
    case (bar_idx_c)
      3'd0: bar_rgb_c = 16'hFFFF;
      3'd1: bar_rgb_c = 16'hFFE0;
      3'd2: bar_rgb_c = 16'h07FF;
      3'd3: bar_rgb_c = 16'h07E0;
      3'd4: bar_rgb_c = 16'hF81F;
      3'd5: bar_rgb_c = 16'hF800;
      3'd6: bar_rgb_c = 16'h001F;
      default: bar_rgb_c = 16'h0000;
    endcase
  end

  assign pix_rgb_c = test_mode ? bar_rgb_c : {hi, d_r};
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pix_rgb_c = {hi, d_r};
`endif

  // Register the camera pins once; all decisions use these copies
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r     <= 1'b0;
      hr_r     <= 1'b0;
      d_r      <= 8'h00;
      vs_act_d <= 1'b0;
      hr_d     <= 1'b0;
    end else begin
      vs_r     <= cam_vsync;
      hr_r     <= cam_href;
      d_r      <= cam_data;
      vs_act_d <= vs_act_c;
      hr_d     <= hr_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_INIT;
    else     state <= state_nxt;
  end

  // Next-state, counter and output logic
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    line_nxt  = line_cnt;
    pix_nxt   = pix_cnt;
    phase_nxt = phase;
    hi_nxt    = hi;
    we_nxt    = 1'b0;
    data_nxt  = sys_data_in;
    done_nxt  = 1'b0;
    valid_nxt = frame_valid;
    fcnt_nxt  = frame_cnt;
    err_nxt   = size_err;

    if (state != WAIT_INIT && !sdram_init_done) begin
      // SDRAM lost: abandon the frame and any half-assembled pixel
      state_nxt = WAIT_INIT;
      phase_nxt = 1'b0;
    end else begin
      unique case (state)
        WAIT_INIT: begin
          if (sdram_init_done) begin
            skip_nxt  = '0;
            state_nxt = (FRAME_SKIP == 0) ? WAIT_VS : SKIP;
          end
        end
        SKIP: begin
          if (frame_end_c) begin
            skip_nxt = skip_cnt + SKIP_W'(1);
            if (skip_cnt + SKIP_W'(1) >= SKIP_LIM) state_nxt = WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (frame_start_c) begin
            state_nxt = CAPTURE;
            line_nxt  = '0;
            pix_nxt   = '0;
            phase_nxt = 1'b0;
          end
        end
        CAPTURE: begin
          if (frame_end_c) begin
            // vsync wins over a still-open line; that partial line is not counted
            if (line_cnt != V_LIM) err_nxt = 1'b1;
            done_nxt  = 1'b1;
            valid_nxt = 1'b1;
            fcnt_nxt  = frame_cnt + CNT_W'(1);
            state_nxt = WAIT_VS;
          end else if (hr_r) begin
            phase_nxt = ~phase;
            if (!phase) begin
              hi_nxt = d_r;
            end else begin
              if (pix_cnt < H_LIM && line_cnt < V_LIM) begin
                we_nxt   = 1'b1;
                data_nxt = pix_rgb_c;
              end
              if (pix_cnt != PIX_MAX) pix_nxt = pix_cnt + PIX_W'(1);
            end
          end else if (line_end_c) begin
            if (pix_cnt != H_LIM || phase) err_nxt = 1'b1;
            if (line_cnt < V_SAT) line_nxt = line_cnt + LINE_W'(1);
            pix_nxt   = '0;
            phase_nxt = 1'b0;
          end
        end
        default: state_nxt = WAIT_INIT;
      endcase
    end
  end

  // Counters, pixel assembly and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt    <= '0;
      line_cnt    <= '0;
      pix_cnt     <= '0;
      phase       <= 1'b0;
      hi          <= 8'h00;
      sys_we      <= 1'b0;
      sys_data_in <= '0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      size_err    <= 1'b0;
    end else begin
      skip_cnt    <= skip_nxt;
      line_cnt    <= line_nxt;
      pix_cnt     <= pix_nxt;
      phase       <= phase_nxt;
      hi          <= hi_nxt;
      sys_we      <= we_nxt;
      sys_data_in <= data_nxt;
      frame_done  <= done_nxt;
      frame_valid <= valid_nxt;
      frame_cnt   <= fcnt_nxt;
      size_err    <= err_nxt;
    end
  end

endmodule
